// File: rtl/inv_mix_columns.sv
// inv_mix_columns: AES InvMixColumns over a full 128-bit state, one state
// per cycle, single registered output stage.
// Optional build macro INV_MIX_COLUMNS_FWD_EN adds a fwd input that selects
// forward MixColumns (fwd=1) or InvMixColumns (fwd=0), sharing the xtime chain.
module inv_mix_columns (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
`ifdef INV_MIX_COLUMNS_FWD_EN
  input  logic         fwd,
`endif
  input  logic [127:0] in,
  output logic         out_valid,
  output logic [127:0] out
);

  // x1/x2/x4/x8 multiples of one byte; every coefficient is an XOR of these.
  typedef struct packed {
    logic [7:0] x1;
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
  } mults_t;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic mults_t multiples(input logic [7:0] b);
    mults_t m;
    m.x1 = b;
    m.x2 = xtime(b);
    m.x4 = xtime(m.x2);
    m.x8 = xtime(m.x4);
    return m;
  endfunction

  // m[r] holds the multiples of row r of the column (m[0] is the MSB byte).
  function automatic logic [31:0] inv_col(input mults_t [3:0] m);
    logic [3:0][7:0] k09, k0b, k0d, k0e;
    for (int r = 0; r < 4; r++) begin
      k09[r] = m[r].x8 ^ m[r].x1;
      k0b[r] = m[r].x8 ^ m[r].x2 ^ m[r].x1;
      k0d[r] = m[r].x8 ^ m[r].x4 ^ m[r].x1;
      k0e[r] = m[r].x8 ^ m[r].x4 ^ m[r].x2;
    end
    return {k0e[0] ^ k0b[1] ^ k0d[2] ^ k09[3],
            k09[0] ^ k0e[1] ^ k0b[2] ^ k0d[3],
            k0d[0] ^ k09[1] ^ k0e[2] ^ k0b[3],
            k0b[0] ^ k0d[1] ^ k09[2] ^ k0e[3]};
  endfunction

`ifdef INV_MIX_COLUMNS_FWD_EN
  function automatic logic [31:0] fwd_col(input mults_t [3:0] m);
    logic [3:0][7:0] k03;
    for (int r = 0; r < 4; r++) begin
      k03[r] = m[r].x2 ^ m[r].x1;
    end
    return {m[0].x2 ^ k03[1]   ^ m[2].x1 ^ m[3].x1,
            m[0].x1 ^ m[1].x2  ^ k03[2]  ^ m[3].x1,
            m[0].x1 ^ m[1].x1  ^ m[2].x2 ^ k03[3],
            k03[0]  ^ m[1].x1  ^ m[2].x1 ^ m[3].x2};
  endfunction
`endif

  logic [127:0] mixed;
  logic [127:0] out_d, out_q;
  logic         out_valid_q;

  // Four independent column units; column c occupies bits [127-32c -: 32].
  for (genvar c = 0; c < 4; c++) begin : g_col
    mults_t [3:0] m;
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign m[r] = multiples(in[127-32*c-8*r -: 8]);
    end
`ifdef INV_MIX_COLUMNS_FWD_EN
    assign mixed[127-32*c -: 32] = fwd ? fwd_col(m) : inv_col(m);
`else
    assign mixed[127-32*c -: 32] = inv_col(m);
`endif
  end

  // Next output: load a new state only when one is presented, else hold.
  always_comb begin
    // NOTE: default first so every path assigns out_d and no latch is inferred.
    out_d = out_q;
    if (in_valid) begin
      out_d = mixed;
    end
  end

  // Output register stage with synchronous reset taking priority over in_valid.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep register updates order-independent.
    if (reset) begin
      out_q       <= 128'h0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= in_valid;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_inv_mix_columns.sv
// Self-checking bench for inv_mix_columns: directed vectors plus random
// states compared against a GF(2^8) matrix-multiply reference model.
// Build with +define+INV_MIX_COLUMNS_FWD_EN to also exercise the fwd path.
module tb_inv_mix_columns;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [127:0] in_s;
  logic         out_valid;
  logic [127:0] out_s;
`ifdef INV_MIX_COLUMNS_FWD_EN
  logic         fwd = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  logic [127:0] exp_out;
  logic         exp_v;

  localparam logic [127:0] VEC_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] VEC_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] FIXED   = 128'hc6c6c6c6_01010101_00000000_ffffffff;
  localparam logic [127:0] V4_IN   = {4{32'h4d7ebdf8}};
  localparam logic [127:0] V4_OUT  = {4{32'h2d26314c}};

  logic [7:0] inv_coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
  logic [7:0] fwd_coef [4] = '{8'h02, 8'h03, 8'h01, 8'h01};

  inv_mix_columns dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
`ifdef INV_MIX_COLUMNS_FWD_EN
    .fwd       (fwd),
`endif
    .in        (in_s),
    .out_valid (out_valid),
    .out       (out_s)
  );

  always #5 clk = ~clk;

  // Shift-and-add GF(2^8) multiply, reducing by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc = 8'h00;
    logic [8:0] t;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= aa;
      t = {aa, 1'b0};
      if (t[8]) t ^= 9'h11b;
      aa = t[7:0];
    end
    return acc;
  endfunction

  // Circulant matrix product per column: o_r = XOR_j coef[(j-r) mod 4] * a_j.
  function automatic logic [127:0] mix_ref(input logic [127:0] s, input bit forward);
    logic [127:0] res = '0;
    logic [7:0]   a [4];
    logic [7:0]   o;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-32*c-8*j -: 8];
      for (int r = 0; r < 4; r++) begin
        o = 8'h00;
        for (int j = 0; j < 4; j++)
          o ^= gmul(forward ? fwd_coef[(j-r+4)%4] : inv_coef[(j-r+4)%4], a[j]);
        res[127-32*c-8*r -: 8] = o;
      end
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Advance one clock and settle just after the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] r_in, fwd_res;
  logic         r_v;

  initial begin
    // Reset held two cycles with a valid input present.
    reset = 1'b1; in_valid = 1'b1; in_s = rand128();
    step();
    check("reset1_out", out_s, 128'h0);
    check("reset1_valid", {127'h0, out_valid}, 128'h0);
    in_s = rand128();
    step();
    check("reset2_out", out_s, 128'h0);
    check("reset2_valid", {127'h0, out_valid}, 128'h0);
    reset = 1'b0; in_valid = 1'b0;
    step();
    check("post_reset_valid", {127'h0, out_valid}, 128'h0);
    check("post_reset_out", out_s, 128'h0);

    // Known vector, then an idle cycle must hold the output.
    in_valid = 1'b1; in_s = VEC_IN;
    step();
    check("vec_out", out_s, VEC_OUT);
    check("vec_model", out_s, mix_ref(VEC_IN, 1'b0));
    check("vec_valid", {127'h0, out_valid}, 128'h1);
    in_valid = 1'b0; in_s = rand128();
    step();
    check("idle_valid", {127'h0, out_valid}, 128'h0);
    check("idle_hold", out_s, VEC_OUT);

    // Fixed points map to themselves.
    in_valid = 1'b1; in_s = FIXED;
    step();
    check("fixed_out", out_s, FIXED);

    // Streaming three back-to-back states.
    in_s = VEC_IN;
    step();
    check("stream0_out", out_s, VEC_OUT);
    check("stream0_valid", {127'h0, out_valid}, 128'h1);
    in_s = FIXED;
    step();
    check("stream1_out", out_s, FIXED);
    check("stream1_valid", {127'h0, out_valid}, 128'h1);
    in_s = V4_IN;
    step();
    check("stream2_out", out_s, V4_OUT);
    check("stream2_valid", {127'h0, out_valid}, 128'h1);

    // Reset coinciding with a valid input discards it.
    in_s = VEC_IN; reset = 1'b1;
    step();
    check("midrst_out", out_s, 128'h0);
    check("midrst_valid", {127'h0, out_valid}, 128'h0);
    reset = 1'b0; in_valid = 1'b0;
    step();
    check("midrst_after_out", out_s, 128'h0);
    check("midrst_after_valid", {127'h0, out_valid}, 128'h0);

    // Random states with random valid gaps.
    exp_out = 128'h0;
    for (int i = 0; i < 40; i++) begin
      r_in = rand128();
      r_v  = 1'($urandom_range(0, 3) != 0);
`ifdef INV_MIX_COLUMNS_FWD_EN
      fwd = 1'($urandom);
`endif
      in_s = r_in; in_valid = r_v;
      step();
`ifdef INV_MIX_COLUMNS_FWD_EN
      if (r_v) exp_out = mix_ref(r_in, fwd);
`else
      if (r_v) exp_out = mix_ref(r_in, 1'b0);
`endif
      exp_v = r_v;
      check("rand_out", out_s, exp_out);
      check("rand_valid", {127'h0, out_valid}, {127'h0, exp_v});
    end

`ifdef INV_MIX_COLUMNS_FWD_EN
    // Forward known vector and random round trips.
    fwd = 1'b1; in_valid = 1'b1; in_s = VEC_OUT;
    step();
    check("fwd_vec_out", out_s, VEC_IN);
    for (int i = 0; i < 10; i++) begin
      r_in = rand128();
      fwd = 1'b1; in_s = r_in;
      step();
      check("fwd_rand_out", out_s, mix_ref(r_in, 1'b1));
      fwd_res = out_s;
      fwd = 1'b0; in_s = fwd_res;
      step();
      check("roundtrip_out", out_s, r_in);
    end
    in_valid = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
